rb_arbiter: RTL and testbench
=============================

RB_ARBITER -- requirements
Module: rb_arbiter

Interface
REQ-001 Parameter: ADR_BITS, default 8, register-bank address width.
REQ-002 clk  input  1  single block clock; all state on rising edge.
REQ-003 resetb  input  1  reset, asynchronous assert, active-low.
REQ-004 m0_req  input  1  master 0 transaction request; held high until m0_ack.
REQ-005 m0_we  input  1  master 0 direction (1 = write, 0 = read); stable while m0_req high.
REQ-006 m0_addr  input  ADR_BITS  master 0 address; stable while m0_req high.
REQ-007 m0_wdata  input  8  master 0 write data; stable while m0_req high.
REQ-008 m0_ack  output  1  master 0 completion pulse, one cycle.
REQ-009 m0_rdata  output  8  master 0 read data; valid while m0_ack high.
REQ-010 m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same directions, widths and meanings as REQ-004..009, for master 1.
REQ-011 address  output  ADR_BITS  register-bank address.
REQ-012 data_write_in  output  8  register-bank write data.
REQ-013 data_read_out  input  8  register-bank read data; registered by the bank one cycle after address.
REQ-014 reg_en  output  1  register-bank access strobe.
REQ-015 write_en  output  1  register-bank write strobe.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, ACCESS, CAPTURE, ACK; all outputs registered.
REQ-018 IDLE: no req -> stay; any req -> latch winner's we/addr/wdata onto write_en-pending/address/data_write_in, record grant owner, -> ACCESS.
REQ-019 Arbitration: single req -> that master; both req -> master not granted last (round-robin); after reset master 0 wins the first tie.
REQ-020 ACCESS (exactly 1 cycle): reg_en = 1, write_en = latched we; -> CAPTURE.
REQ-021 CAPTURE (1 cycle): reg_en = write_en = 0, address held; at its end data_read_out is loaded into the owner's rdata register, owner's ack set; -> ACK.
REQ-022 ACK (1 cycle): owner ack = 1, other ack = 0; -> IDLE; ack never high in two consecutive cycles.
REQ-023 Latency: req sampled high at edge N -> write_en/reg_en high in cycle N+1 -> ack high in cycle N+3; next grant earliest at edge N+4.
REQ-024 Write transactions return in rdata the pre-write register value (bank read path samples the same address during ACCESS).
REQ-025 Unmapped address: no special handling; rdata = bank value (0x00).
REQ-026 address and data_write_in hold the last granted values in IDLE; rdata registers hold until next own transaction.
REQ-027 Requests arriving outside IDLE are not sampled; they wait (req must stay high) and are arbitrated in the next IDLE.
REQ-028 Masters deassert req in the cycle after ack; a req still high in IDLE is a new transaction.
REQ-029 req/we/addr/wdata changes after grant have no effect on the current transaction.

Reset
REQ-030 resetb low: state = IDLE, address = 0, data_write_in = 0, reg_en = 0, write_en = 0, m0_ack = m1_ack = 0, m0_rdata = m1_rdata = 0x00, busy = 0, last-grant = master 1, immediately (asynchronous).
REQ-031 Reset mid-transaction aborts it: no ack issued; if asserted during ACCESS the bank write is not guaranteed; pending req re-arbitrated after release.
REQ-032 First req sampled at the first rising edge after resetb deasserts.

Verification
REQ-033 m0 write addr 0x12 data 0xA5 -> write_en=1 for 1 cycle with address 0x12, data_write_in 0xA5; m0_ack at N+3; m0 read 0x12 -> m0_rdata 0xA5.
REQ-034 After reset, m0 and m1 req same cycle (m0 read 0x00, m1 read 0x03) -> m0 served first (rdata 0x02), m1 next (rdata 0x11), m1_ack 4 cycles after m0_ack.
REQ-035 Both masters requesting continuously -> grants alternate m0, m1, m0, m1; one ack every 4 cycles, never both acks high.
REQ-036 m1 read unmapped addr 0x40 -> m1_rdata 0x00, m1_ack pulse 1 cycle; m0_rdata unchanged.
REQ-037 resetb low during ACCESS of m0 write -> all outputs to REQ-030 values same cycle, no m0_ack; after release m0 re-granted and acked.
REQ-038 m1 write addr 0x14 data 0x33 over reset value 0x85 -> m1_rdata 0x85 with ack; subsequent read returns 0x33.

Source files
------------

// File: rtl/rb_arbiter_if.sv
// Master-side request/acknowledge bundle for the two-master register-bank arbiter.
// The master modport is the requesting side; the slave modport is the arbiter.
interface rb_arbiter_if #(
    parameter int ADR_BITS = 8
);
    logic                m0_req;
    logic                m0_we;
    logic [ADR_BITS-1:0] m0_addr;
    logic [7:0]          m0_wdata;
    logic                m0_ack;
    logic [7:0]          m0_rdata;

    logic                m1_req;
    logic                m1_we;
    logic [ADR_BITS-1:0] m1_addr;
    logic [7:0]          m1_wdata;
    logic                m1_ack;
    logic [7:0]          m1_rdata;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata
    );
endinterface

// File: rtl/rb_arbiter.sv
// Round-robin arbiter giving two masters single-beat access to a register bank.
// Every transaction is IDLE -> ACCESS -> CAPTURE -> ACK; all outputs are flops.
module rb_arbiter #(
    parameter int ADR_BITS = 8
) (
    input  logic                clk,
    input  logic                resetb,
    rb_arbiter_if.slave         mst,
    output logic [ADR_BITS-1:0] address,
    output logic [7:0]          data_write_in,
    input  logic [7:0]          data_read_out,
    output logic                reg_en,
    output logic                write_en,
    output logic                busy
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic [ADR_BITS-1:0] addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                reg_en_q, reg_en_d;
    logic                write_en_q, write_en_d;
    logic                busy_q, busy_d;
    logic [1:0]          ack_q, ack_d;
    logic [7:0]          rdata_q [2];
    logic [7:0]          rdata_d [2];

    logic [1:0] req;
    logic       grant;

    assign req = {mst.m1_req, mst.m0_req};

    // On a tie the master not served last wins; otherwise the lone requester.
    assign grant = (req == 2'b11) ? ~last_q : req[1];

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        reg_en_d   = 1'b0;
        write_en_d = 1'b0;
        ack_d      = 2'b00;
        rdata_d    = rdata_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d    = grant;
                    last_d     = grant;
                    addr_d     = grant ? mst.m1_addr  : mst.m0_addr;
                    wdata_d    = grant ? mst.m1_wdata : mst.m0_wdata;
                    write_en_d = grant ? mst.m1_we    : mst.m0_we;
                    reg_en_d   = 1'b1;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // Bank output now reflects the address presented during ACCESS,
                // which for a write is the value before the write landed.
                rdata_d[owner_q] = data_read_out;
                ack_d[owner_q]   = 1'b1;
                state_d          = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            reg_en_q   <= 1'b0;
            write_en_q <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 2'b00;
            rdata_q[0] <= 8'h00;
            rdata_q[1] <= 8'h00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            reg_en_q   <= reg_en_d;
            write_en_q <= write_en_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            rdata_q[0] <= rdata_d[0];
            rdata_q[1] <= rdata_d[1];
        end
    end

    assign address       = addr_q;
    assign data_write_in = wdata_q;
    assign reg_en        = reg_en_q;
    assign write_en      = write_en_q;
    assign busy          = busy_q;
    assign mst.m0_ack    = ack_q[0];
    assign mst.m1_ack    = ack_q[1];
    assign mst.m0_rdata  = rdata_q[0];
    assign mst.m1_rdata  = rdata_q[1];
endmodule

// File: tb/tb_rb_arbiter.sv
// Directed bench for rb_arbiter: a registered-read bank model plus two masters
// driven from one sequence; each check goes through the check task.
module tb_rb_arbiter;
    logic       clk = 1'b0;
    logic       resetb = 1'b1;
    logic [7:0] address;
    logic [7:0] data_write_in;
    logic [7:0] data_read_out;
    logic       reg_en;
    logic       write_en;
    logic       busy;

    int total = 0;
    int bad   = 0;

    rb_arbiter_if #(.ADR_BITS(8)) bus ();

    rb_arbiter #(.ADR_BITS(8)) dut (
        .clk           (clk),
        .resetb        (resetb),
        .mst           (bus.slave),
        .address       (address),
        .data_write_in (data_write_in),
        .data_read_out (data_read_out),
        .reg_en        (reg_en),
        .write_en      (write_en),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Bank: 0x00-0x3F mapped, everything above reads 0x00.
    logic [7:0] mem [64] = '{0: 8'h02, 3: 8'h11, 20: 8'h85, default: 8'h00};

    always @(posedge clk) begin
        if (reg_en && write_en && address[7:6] == 2'b00)
            mem[address[5:0]] <= data_write_in;
        data_read_out <= (address[7:6] == 2'b00) ? mem[address[5:0]] : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input bit m, input bit v, input bit we,
                           input logic [7:0] addr, input logic [7:0] wdata);
        if (!m) begin
            bus.m0_req = v; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
        end else begin
            bus.m1_req = v; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
        end
    endtask

    // One transaction starting with the arbiter idle; ack expected 3 negedges on.
    task automatic xact(input bit m, input bit we, input logic [7:0] addr,
                        input logic [7:0] wdata, input bit chk_rd,
                        input logic [7:0] exp_rd, input string tag);
        int   got_k;
        logic ack;
        logic [7:0] rd;
        got_k = -1;
        rd    = 8'h00;
        @(negedge clk);
        set_req(m, 1'b1, we, addr, wdata);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check({tag, "_reg_en"}, reg_en, 1'b1);
                check({tag, "_write_en"}, write_en, we);
                check({tag, "_address"}, address, addr);
                if (we) check({tag, "_wdata"}, data_write_in, wdata);
            end
            if (k == 2) check({tag, "_strobe_off"}, {reg_en, write_en}, 2'b00);
            ack = m ? bus.m1_ack : bus.m0_ack;
            if (got_k > 0 && k == got_k + 1) begin
                check({tag, "_ack_1cyc"}, ack, 1'b0);
                break;
            end
            if (ack && got_k < 0) begin
                got_k = k;
                rd    = m ? bus.m1_rdata : bus.m0_rdata;
                check({tag, "_other_ack"}, m ? bus.m0_ack : bus.m1_ack, 1'b0);
                set_req(m, 1'b0, we, addr, wdata);
            end
        end
        check({tag, "_latency"}, got_k, 3);
        if (chk_rd) check({tag, "_rdata"}, rd, exp_rd);
        set_req(m, 1'b0, 1'b0, addr, wdata);
        $display("xact %s: m%0d we=%0d addr=%02h wdata=%02h rdata=%02h ack_at=%0d",
                 tag, m, we, addr, wdata, rd, got_k);
    endtask

    initial begin
        int a0, a1, n_acks;
        int exp_k [4] = '{3, 7, 11, 15};
        bit exp_m [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

        set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        #1 resetb = 1'b0;
        #2;
        check("rst_outputs", {address, data_write_in, reg_en, write_en, busy,
                              bus.m0_ack, bus.m1_ack}, 21'h0);
        check("rst_rdata", {bus.m0_rdata, bus.m1_rdata}, 16'h0000);
        repeat (3) @(negedge clk);
        resetb = 1'b1;

        // Tie right after reset: m0 first, m1 four cycles later.
        set_req(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b1, 1'b0, 8'h03, 8'h00);
        a0 = -1; a1 = -1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (bus.m0_ack && bus.m1_ack) check("tie_both_ack", 1'b1, 1'b0);
            if (bus.m0_ack && a0 < 0) begin
                a0 = k; set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            end
            if (bus.m1_ack && a1 < 0) begin
                a1 = k; set_req(1'b1, 1'b0, 1'b0, 8'h03, 8'h00);
            end
        end
        check("tie_m0_ack", a0, 3);
        check("tie_m1_ack", a1, 7);
        check("tie_m0_rdata", bus.m0_rdata, 8'h02);
        check("tie_m1_rdata", bus.m1_rdata, 8'h11);
        $display("xact tie: m0 ack_at=%0d rdata=%02h, m1 ack_at=%0d rdata=%02h",
                 a0, bus.m0_rdata, a1, bus.m1_rdata);

        xact(1'b0, 1'b1, 8'h12, 8'hA5, 1'b1, 8'h00, "m0_wr12");
        xact(1'b0, 1'b0, 8'h12, 8'h00, 1'b1, 8'hA5, "m0_rd12");
        xact(1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 8'h00, "m1_rd40");
        check("m0_rdata_kept", bus.m0_rdata, 8'hA5);

        // Both masters hold req: grants alternate, last grant was m1 so m0 first.
        set_req(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        set_req(1'b1, 1'b1, 1'b0, 8'h03, 8'h00);
        n_acks = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (bus.m0_ack && bus.m1_ack) check("rr_both_ack", 1'b1, 1'b0);
            if (bus.m0_ack || bus.m1_ack) begin
                if (n_acks < 4) begin
                    check("rr_ack_cycle", k, exp_k[n_acks]);
                    check("rr_ack_owner", bus.m1_ack, exp_m[n_acks]);
                    check("rr_rdata", bus.m1_ack ? bus.m1_rdata : bus.m0_rdata,
                          exp_m[n_acks] ? 8'h11 : 8'h02);
                end
                n_acks++;
            end
            if (k == 16) begin
                set_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
                set_req(1'b1, 1'b0, 1'b0, 8'h03, 8'h00);
            end
        end
        check("rr_ack_count", n_acks, 4);
        $display("xact round_robin: acks=%0d", n_acks);
        repeat (2) @(negedge clk);
        check("rr_idle", busy, 1'b0);

        xact(1'b1, 1'b1, 8'h14, 8'h33, 1'b1, 8'h85, "m1_wr14");
        xact(1'b1, 1'b0, 8'h14, 8'h00, 1'b1, 8'h33, "m1_rd14");

        // Reset asserted while m0's write is in ACCESS.
        @(negedge clk);
        set_req(1'b0, 1'b1, 1'b1, 8'h20, 8'h77);
        @(negedge clk);
        check("ra_in_access", reg_en, 1'b1);
        #1 resetb = 1'b0;
        #1;
        check("ra_rst_outputs", {address, data_write_in, reg_en, write_en, busy,
                                 bus.m0_ack, bus.m1_ack}, 21'h0);
        check("ra_rst_rdata", {bus.m0_rdata, bus.m1_rdata}, 16'h0000);
        a0 = -1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (bus.m0_ack) a0 = k;
        end
        check("ra_no_ack_in_rst", a0, -1);
        resetb = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.m0_ack && a0 < 0) begin
                a0 = k; set_req(1'b0, 1'b0, 1'b1, 8'h20, 8'h77);
            end
        end
        check("ra_regrant_ack", a0, 3);
        set_req(1'b0, 1'b0, 1'b0, 8'h20, 8'h00);
        $display("xact reset_abort: m0 regrant ack_at=%0d", a0);
        xact(1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 8'h77, "m0_rd20");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
